// File: rtl/multiplier_simd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_simd_pipe
// Brief    : Pipelined precision-scalable SIMD multiplier (1x/2x/4x lanes) with
//            stall, valid tracking and zero-operand gating. Optional counters
//            under MULT_SIMD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_simd_pipe #(
    parameter int DATA_W = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_en_ff,
    input  logic                  i_valid,
    input  logic [1:0]            i_mode,
    input  logic                  i_signed,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    input  logic                  i_cnt_clr,
    output logic                  o_valid,
    output logic [2*DATA_W-1:0]   o_prod,
    output logic                  o_mode_err,
    output logic [CNT_W-1:0]      o_op_cnt,
    output logic [CNT_W-1:0]      o_zero_cnt
);

    localparam int       c_PW   = 2 * DATA_W;
    localparam int       c_HALF = DATA_W / 2;
    localparam int       c_QTR  = DATA_W / 4;
    localparam logic [1:0] c_MODE_HALF = 2'd1;
    localparam logic [1:0] c_MODE_QTR  = 2'd2;
    localparam logic [1:0] c_MODE_RSVD = 2'd3;

    logic [c_PW-1:0] w_full_a;
    logic [c_PW-1:0] w_full_b;
    logic [c_PW-1:0] w_full_p;
    logic [c_PW-1:0] w_half_p;
    logic [c_PW-1:0] w_qtr_p;
    logic [c_PW-1:0] w_pp;
    logic            w_zero;
    logic            w_err;

    // Each lane is extended to twice its width so one multiply yields the exact
    // signed or unsigned product in the low bits.
    assign w_full_a = {{DATA_W{i_signed & i_a[DATA_W-1]}}, i_a};
    assign w_full_b = {{DATA_W{i_signed & i_b[DATA_W-1]}}, i_b};
    assign w_full_p = w_full_a * w_full_b;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_half
            logic [DATA_W-1:0] w_ea;
            logic [DATA_W-1:0] w_eb;
            assign w_ea = {{c_HALF{i_signed & i_a[k*c_HALF+c_HALF-1]}}, i_a[k*c_HALF +: c_HALF]};
            assign w_eb = {{c_HALF{i_signed & i_b[k*c_HALF+c_HALF-1]}}, i_b[k*c_HALF +: c_HALF]};
            assign w_half_p[k*DATA_W +: DATA_W] = w_ea * w_eb;
        end
        for (genvar k = 0; k < 4; k++) begin : g_qtr
            logic [c_HALF-1:0] w_ea;
            logic [c_HALF-1:0] w_eb;
            assign w_ea = {{c_QTR{i_signed & i_a[k*c_QTR+c_QTR-1]}}, i_a[k*c_QTR +: c_QTR]};
            assign w_eb = {{c_QTR{i_signed & i_b[k*c_QTR+c_QTR-1]}}, i_b[k*c_QTR +: c_QTR]};
            assign w_qtr_p[k*c_HALF +: c_HALF] = w_ea * w_eb;
        end
    endgenerate

    always_comb begin
        w_pp = w_full_p;
        case (i_mode)
            c_MODE_HALF: w_pp = w_half_p;
            c_MODE_QTR:  w_pp = w_qtr_p;
            default:     w_pp = w_full_p;
        endcase
    end

    assign w_zero = (i_a == '0) || (i_b == '0);
    assign w_err  = (i_mode == c_MODE_RSVD);

    // Control flags advance on every enabled cycle, bubbles included.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vld <= '0;
            r_err <= '0;
        end else if (i_en_ff) begin
            r_vld[0] <= i_valid;
            r_err[0] <= w_err;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    logic            w_in_vld;
    logic            w_in_zero;
    logic [c_PW-1:0] w_in_data;

    generate
        if (STAGES == 1) begin : g_single
            assign w_in_vld  = i_valid;
            assign w_in_zero = w_zero;
            assign w_in_data = w_pp;
        end else begin : g_multi
            logic [c_PW-1:0] r_data [STAGES-1];
            logic [STAGES-2:0] r_zero;

            // Data registers load only for valid, non-zero ops (operand isolation).
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_zero <= '0;
                    for (int i = 0; i < STAGES-1; i++) begin
                        r_data[i] <= '0;
                    end
                end else if (i_en_ff) begin
                    r_zero[0] <= w_zero;
                    if (i_valid && !w_zero) begin
                        r_data[0] <= w_pp;
                    end
                    for (int i = 1; i < STAGES-1; i++) begin
                        r_zero[i] <= r_zero[i-1];
                        if (r_vld[i-1] && !r_zero[i-1]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign w_in_vld  = r_vld[STAGES-2];
            assign w_in_zero = r_zero[STAGES-2];
            assign w_in_data = r_data[STAGES-2];
        end
    endgenerate

    logic [c_PW-1:0] r_prod;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_prod <= '0;
        end else if (i_en_ff && w_in_vld) begin
            r_prod <= w_in_zero ? '0 : w_in_data;
        end
    end

    assign o_valid    = r_vld[STAGES-1];
    assign o_mode_err = r_vld[STAGES-1] & r_err[STAGES-1];
    assign o_prod     = r_prod;

`ifdef MULT_SIMD_PERF_CNT_EN
    logic             w_cap;
    logic [CNT_W-1:0] r_op_cnt;
    logic [CNT_W-1:0] r_zero_cnt;

    assign w_cap = i_valid & i_en_ff;

    // Clear has priority; both counters saturate at all-ones.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_op_cnt   <= '0;
            r_zero_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_op_cnt   <= '0;
            r_zero_cnt <= '0;
        end else if (w_cap) begin
            if (r_op_cnt != '1) begin
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
            if (w_zero && (r_zero_cnt != '1)) begin
                r_zero_cnt <= r_zero_cnt + CNT_W'(1);
            end
        end
    end

    assign o_op_cnt   = r_op_cnt;
    assign o_zero_cnt = r_zero_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_cnt_clr;
    assign o_op_cnt     = '0;
    assign o_zero_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: doc/multiplier_simd_pipe.md
Name: multiplier_simd_pipe

Overview:
Precision-scalable, pipelined SIMD multiplier for the systolic-array PE datapath; successor to the fixed-width selectable multiplier wrapper.
- One DATA_W x DATA_W product, two DATA_W/2 lane products, or four DATA_W/4 lane products, with per-operation mode and signedness.
- Valid tracking, stall via i_en_ff, and zero-operand gating through a STAGES-deep pipeline.

Parameters:
DATA_W, 16, operand width; must be a multiple of 4 and >= 8
STAGES, 2, pipeline depth = latency in enabled cycles; legal range 1..4
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_en_ff  in  1  pipeline enable; 0 freezes every pipeline register
i_valid  in  1  operands valid this cycle
i_mode  in  2  0=1xDATA_W, 1=2xDATA_W/2, 2=4xDATA_W/4, 3=reserved
i_signed  in  1  1 = two's-complement lanes, 0 = unsigned lanes
i_a  in  DATA_W  operand A, lanes packed LSB-first
i_b  in  DATA_W  operand B, lanes packed LSB-first
i_cnt_clr  in  1  synchronous clear of the performance counters
o_valid  out  1  o_prod valid
o_prod  out  2*DATA_W  packed lane products
o_mode_err  out  1  output op was issued with i_mode=3
o_op_cnt  out  CNT_W  issued-op count
o_zero_cnt  out  CNT_W  zero-gated-op count

Behaviour:
- Reset (async on i_rstn low, released synchronously to i_clk): all pipeline valid bits, o_valid, o_prod, o_mode_err, o_op_cnt and o_zero_cnt = 0.
- Capture: an op is captured when i_valid=1 and i_en_ff=1. Mode, signed and zero flags are captured with the data and travel with it down the pipe.
- Latency: o_valid rises exactly STAGES enabled cycles after capture. Cycles with i_en_ff=0 add no latency count and hold all state, including o_valid and o_prod.
- Bubbles: an enabled cycle with i_valid=0 inserts a bubble; o_valid=0 for that slot.
- o_prod holds its last value while o_valid=0, i.e. data registers load only on valid slots.
- Lane mapping:
  - Mode 0: o_prod = a*b, full 2*DATA_W.
  - Mode 1: lane k (k=0,1) uses a[k*H +: H] and b[k*H +: H], H=DATA_W/2; result goes to o_prod[k*DATA_W +: DATA_W].
  - Mode 2: lane k (k=0..3) uses Q=DATA_W/4 bit slices; result goes to o_prod[k*DATA_W/2 +: DATA_W/2].
  - Each lane product is exact and full-width for its lane, sign-extended when i_signed=1, zero-extended otherwise.
- Mode 3: computed as mode 0; o_mode_err=1 alongside that op's o_valid, 0 otherwise.
- Zero gating: if i_a==0 or i_b==0 at capture, the arithmetic registers are not loaded for that op (operand isolation). A zero flag propagates instead and the output stage forces o_prod=0. Gating is whole-word, not per lane.
- Structure: partial-product generation in stage 1; the remaining STAGES-1 stages hold and reduce. Retiming within those stages is left to synthesis. STAGES=1 means the output register only.
- Mid-operation reset: in-flight ops are discarded with no spurious o_valid after release.
- Back-to-back: one op per enabled cycle; mixed modes in consecutive cycles are legal and must not interfere.

Optional Feature:
Macro: MULT_SIMD_PERF_CNT_EN
- Defined:
  - o_op_cnt increments on each capture.
  - o_zero_cnt increments on each zero-gated capture.
  - Both counters saturate at 2^CNT_W-1.
  - i_cnt_clr=1 zeroes both on the next clock edge; clear wins over a simultaneous increment.
  - Counters ignore i_en_ff=0 cycles because no capture occurs.
- Undefined: no counter flops; o_op_cnt and o_zero_cnt tied to 0; i_cnt_clr ignored.

Test Plan:
1. DATA_W=16, STAGES=2, mode 0, signed: a=0xFFFE (-2), b=0x0003 -> o_prod=0xFFFFFFFA with o_valid exactly 2 cycles after capture; unsigned same operands -> 0x0002FFFA.
2. Mode 1, signed: a=0x7F80, b=0x02FF -> lane0 0x80*0xFF = (-128)*(-1) = 0x0080; lane1 0x7F*0x02 = 0x00FE; o_prod=0x00FE0080.
3. Mode 2, unsigned: a=0xF00F, b=0x1FF1 -> lane products 0x0F, 0x00, 0x00, 0x0F; o_prod=0x0F00000F. Then signed: a=0x8000 (lane3=-8), b=0x8000 -> lane3=0x40, o_prod=0x40000000.
4. Stream 5 ops with i_en_ff low for 3 cycles mid-stream and one i_valid=0 bubble -> outputs appear in order, held during stall, one gap for the bubble, no duplicates.
5. a=0, b=0x1234 -> o_prod=0 with o_valid. With the macro defined, o_zero_cnt=1 and o_op_cnt=1; i_cnt_clr together with a new capture -> both counters 0. Preset to 2^CNT_W-1 -> counters hold.
6. Mode 3 op -> mode-0 product with o_mode_err=1. Assert i_rstn low with 2 ops in flight -> o_valid=0 and o_prod=0 immediately; no o_valid after release.
